// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 LSB-first UART transmitter fed by a small circular FIFO.
// The host pushes bytes with a valid/ready handshake. A frame state machine
// pops one byte per frame and shifts it out at CLKS_PER_BIT clocks per bit.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [15:0]   CNT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          wr_en;
    logic          pop;

    // Frame state machine
    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          serial_q, serial_d;
    logic          active_q, active_d;
    logic          done_q, done_d;

    // Ready is registered from the count, so a full FIFO refuses a write even
    // in a cycle where the state machine pops.
    assign wr_en = i_Tx_DV && ready_q;

    // FIFO pointer and occupancy next-state; pointers wrap with their width.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(wr_en) - CW'(pop);
        ready_d = (count_d < DEPTH_C);
    end

    // FIFO control registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // FIFO data array; contents need no reset since the count guards reads.
    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_Tx_Byte;
        end
    end

    // Frame sequencing plus registered line outputs decoded from the next state,
    // so the line changes on the same edge the state does.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        serial_d = 1'b1;
        active_d = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CLEANUP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_CLEANUP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase

        case (state_d)
            S_START: begin
                serial_d = 1'b0;
                active_d = 1'b1;
            end
            S_DATA: begin
                serial_d = shift_d[bit_d];
                active_d = 1'b1;
            end
            S_STOP: begin
                serial_d = 1'b1;
                active_d = 1'b1;
            end
            S_CLEANUP: begin
                serial_d = 1'b1;
                done_d   = 1'b1;
            end
            default: begin
                serial_d = 1'b1;
            end
        endcase
    end

    // Frame state, counters and line outputs; reset aborts any frame in flight.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // Shift register holds the byte being sent; it is loaded only on a pop.
    always_ff @(posedge i_Clock) begin
        shift_q <= shift_d;
    end

    assign o_Tx_Ready   = ready_q;
    assign o_Fifo_Count = count_q;
    assign o_Tx_Serial  = serial_q;
    assign o_Tx_Active  = active_q;
    assign o_Tx_Done    = done_q;

endmodule
